// File: rtl/booth_divider_pkg.sv
// Shared definitions for the signed restoring divider: state encoding,
// default operand width and the divide-by-zero quotient pattern.
package booth_divider_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int DEFAULT_WIDTH = 8;
    localparam int MAX_WIDTH     = 16;

    // Quotient reported on divide-by-zero; sliced down to the operand width.
    localparam logic [MAX_WIDTH-1:0] DIV_ZERO_QUOT = {MAX_WIDTH{1'b1}};

endpackage

// File: rtl/booth_divider_div_step.sv
// One restoring-division iteration: trial-subtract the divisor from the
// shifted partial remainder and keep the difference only if it is non-negative.
module booth_divider_div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   part_rem,
    input  logic [WIDTH:0]   divisor_mag,
    output logic [WIDTH-1:0] next_rem,
    output logic             q_bit
);

    logic [WIDTH+1:0] diff;
    logic             unused_diff;

    assign diff = {1'b0, part_rem} - {1'b0, divisor_mag};
    assign q_bit = ~diff[WIDTH+1];

    // The kept remainder is always below the divisor magnitude (<= 2^(WIDTH-1)),
    // so bit WIDTH of either candidate is zero and can be dropped.
    assign next_rem = q_bit ? diff[WIDTH-1:0] : part_rem[WIDTH-1:0];
    assign unused_diff = diff[WIDTH];

endmodule

// File: rtl/booth_divider.sv
// Sequential signed radix-2 restoring divider: one quotient bit per clock,
// quotient truncated toward zero, remainder carrying the dividend's sign.
module booth_divider
    import booth_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero,
    output logic             overflow
);

    localparam int              CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH:0]       div_q, div_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 neg_quo_q, neg_quo_d;
    logic                 neg_rem_q, neg_rem_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [WIDTH-1:0]     quo_q, quo_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic                 dz_q, dz_d;
    logic                 ov_q, ov_d;

    logic [WIDTH:0]       dvd_ext, dvd_mag;
    logic [WIDTH:0]       dsr_ext, dsr_mag;
    logic [WIDTH-1:0]     step_rem;
    logic                 step_q_bit;
    logic                 unused_top;

    // Magnitudes formed one bit wider so the most-negative value does not wrap.
    assign dvd_ext = {dividend[WIDTH-1], dividend};
    assign dsr_ext = {divisor[WIDTH-1], divisor};
    assign dvd_mag = dividend[WIDTH-1] ? -dvd_ext : dvd_ext;
    assign dsr_mag = divisor[WIDTH-1] ? -dsr_ext : dsr_ext;
    assign unused_top = dvd_mag[WIDTH];

    booth_divider_div_step #(.WIDTH(WIDTH)) u_step (
        .part_rem    (acc_q[2*WIDTH-1:WIDTH-1]),
        .divisor_mag (div_q),
        .next_rem    (step_rem),
        .q_bit       (step_q_bit)
    );

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        div_d     = div_q;
        cnt_d     = cnt_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dz_d      = dz_q;
        ov_d      = ov_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    busy_d = 1'b1;
                    dz_d   = 1'b0;
                    ov_d   = 1'b0;
                    if (divisor == '0) begin
                        quo_d   = DIV_ZERO_QUOT[WIDTH-1:0];
                        rem_d   = dividend;
                        dz_d    = 1'b1;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else if (dividend == MOST_NEG && divisor == '1) begin
                        quo_d   = MOST_NEG;
                        rem_d   = '0;
                        ov_d    = 1'b1;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        acc_d     = {{WIDTH{1'b0}}, dvd_mag[WIDTH-1:0]};
                        div_d     = dsr_mag;
                        neg_quo_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        neg_rem_d = dividend[WIDTH-1];
                        cnt_d     = CNT_INIT;
                        state_d   = S_CALC;
                    end
                end
            end
            S_CALC: begin
                // Shift left by one, with the new quotient bit entering at the LSB.
                acc_d = {step_rem, acc_q[WIDTH-2:0], step_q_bit};
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                quo_d   = neg_quo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                rem_d   = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            div_q     <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            quo_q     <= '0;
            rem_q     <= '0;
            dz_q      <= 1'b0;
            ov_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dz_q      <= dz_d;
            ov_q      <= ov_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign div_zero  = dz_q;
    assign overflow  = ov_q;

endmodule

// File: tb/tb_booth_divider.sv
// Directed bench for booth_divider (WIDTH=8) with hand-computed quotients,
// remainders, flags and done latency.
module tb_booth_divider;

    localparam int W = 8;
    localparam int MAX_WAIT = 40;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_zero;
    logic         overflow;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];

    booth_divider #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Launch one division; optionally pulse a second start at cycle pulse_at
    // (cycle 1 is the cycle right after the accept edge), which must be ignored.
    task automatic run_div(input string tag,
                           input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] eq, input logic [W-1:0] er,
                           input logic edz, input logic eov,
                           input int elat, input int pulse_at);
        int lat;
        exp_q.push_back(eq);
        exp_q.push_back(er);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        if (!done) chk({tag, "_busy1"}, 32'(busy), 32'd1);
        while (!done && lat < MAX_WAIT) begin
            if (lat == pulse_at) begin
                dividend = 8'd9;
                divisor  = 8'd2;
                start    = 1'b1;
            end
            @(negedge clk);
            start = 1'b0;
            lat++;
        end
        chk({tag, "_seen_done"}, 32'(done), 32'd1);
        chk({tag, "_lat"}, 32'(lat), 32'(elat));
        chk({tag, "_quo"}, 32'(quotient), 32'(exp_q.pop_front()));
        chk({tag, "_rem"}, 32'(remainder), 32'(exp_q.pop_front()));
        chk({tag, "_dz"}, 32'(div_zero), 32'(edz));
        chk({tag, "_ov"}, 32'(overflow), 32'(eov));
        chk({tag, "_busy_at_done"}, 32'(busy), 32'd1);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_busy_after"}, 32'(busy), 32'd0);
        chk({tag, "_quo_hold"}, 32'(quotient), 32'(eq));
    endtask

    initial begin
        int done_cnt;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_quo", 32'(quotient), 32'd0);
        chk("rst_rem", 32'(remainder), 32'd0);
        chk("rst_dz", 32'(div_zero), 32'd0);
        chk("rst_ov", 32'(overflow), 32'd0);
        rst = 1'b0;

        run_div("p100_7",   8'd100,  8'd7,    8'h0E, 8'h02, 1'b0, 1'b0, 10, 0);
        run_div("m100_7",   8'h9C,   8'd7,    8'hF2, 8'hFE, 1'b0, 1'b0, 10, 0);
        run_div("p100_m7",  8'd100,  8'hF9,   8'hF2, 8'h02, 1'b0, 1'b0, 10, 0);
        run_div("p7_0",     8'd7,    8'd0,    8'hFF, 8'h07, 1'b1, 1'b0, 1,  0);
        run_div("m128_m1",  8'h80,   8'hFF,   8'h80, 8'h00, 1'b0, 1'b1, 1,  0);
        run_div("m128_3",   8'h80,   8'd3,    8'hD6, 8'hFE, 1'b0, 1'b0, 10, 0);
        run_div("p127_1",   8'd127,  8'd1,    8'h7F, 8'h00, 1'b0, 1'b0, 10, 0);
        run_div("p5_10",    8'd5,    8'd10,   8'h00, 8'h05, 1'b0, 1'b0, 10, 0);
        run_div("m7_m2",    8'hF9,   8'hFE,   8'h03, 8'hFF, 1'b0, 1'b0, 10, 0);
        run_div("m1_0",     8'hFF,   8'd0,    8'hFF, 8'hFF, 1'b1, 1'b0, 1,  0);
        run_div("m128_m128",8'h80,   8'h80,   8'h01, 8'h00, 1'b0, 1'b0, 10, 0);
        run_div("p50_5_ign",8'd50,   8'd5,    8'h0A, 8'h00, 1'b0, 1'b0, 10, 3);

        // Reset in the middle of 100/7 must abort with no done pulse.
        @(negedge clk);
        dividend = 8'd100;
        divisor  = 8'd7;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_quo", 32'(quotient), 32'd0);
        chk("mid_rst_rem", 32'(remainder), 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        chk("mid_rst_no_done", 32'(done_cnt), 32'd0);
        run_div("p20_3",    8'd20,   8'd3,    8'h06, 8'h02, 1'b0, 1'b0, 10, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
